// File: rtl/jpeg_pkg.sv
// Shared constants for the JPEG coefficient path.
//   BLOCK_SIZE   : coefficients per 8x8 block
//   ZIGZAG_TABLE : zigzag scan position -> raster position (standard JPEG order)
//   zz2raster()  : lookup helper over ZIGZAG_TABLE
package jpeg_pkg;

    localparam int BLOCK_SIZE = 64;

    localparam logic [5:0] ZIGZAG_TABLE [BLOCK_SIZE] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [5:0] zz2raster(input logic [5:0] zz_idx);
        return ZIGZAG_TABLE[zz_idx];
    endfunction

endpackage

// File: rtl/zigzag_rom.sv
// Combinational zigzag-to-raster index lookup.
//   i_zz_idx     : zigzag scan position 0-63
//   o_raster_idx : corresponding raster position 0-63
module zigzag_rom
    import jpeg_pkg::*;
(
    input  logic [5:0] i_zz_idx,
    output logic [5:0] o_raster_idx
);

    assign o_raster_idx = zz2raster(i_zz_idx);

endmodule

// File: rtl/coeff_block_pingpong.sv
// Ping-pong coefficient block accumulator.
// Serial coefficients fill one 64-entry bank while the other bank is held for
// the downstream transform. Each bank carries a written-mask so unwritten
// positions read as zero without a clear pass.
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   coeff_in         : signed coefficient value
//   coeff_index      : position in block (zigzag or raster, see ZIGZAG_EN)
//   coeff_valid      : coefficient present this cycle
//   block_done       : closes the current block (may coincide with coeff_valid)
//   comp_id          : component tag, latched with the accepted block_done
//   coeff_ready      : coeff_valid/block_done are accepted this cycle
//   block_out_flat   : presented block, raster entry i at [i*WIDTH +: WIDTH]
//   block_comp       : tag of the presented block
//   block_valid      : presented block is valid
//   block_ready      : downstream accepts the presented block
//   blocks_buffered  : number of full banks (0-2)
module coeff_block_pingpong
    import jpeg_pkg::*;
#(
    parameter int WIDTH     = 12,
    parameter bit ZIGZAG_EN = 1'b1,
    parameter int COMP_W    = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [WIDTH-1:0]     coeff_in,
    input  logic [5:0]                  coeff_index,
    input  logic                        coeff_valid,
    input  logic                        block_done,
    input  logic [COMP_W-1:0]           comp_id,
    output logic                        coeff_ready,
    output logic [WIDTH*BLOCK_SIZE-1:0] block_out_flat,
    output logic [COMP_W-1:0]           block_comp,
    output logic                        block_valid,
    input  logic                        block_ready,
    output logic [1:0]                  blocks_buffered
);

    logic signed [WIDTH-1:0] r_data [2][BLOCK_SIZE];
    logic [BLOCK_SIZE-1:0]   r_wmask [2];
    logic [1:0]              r_full;
    logic [COMP_W-1:0]       r_comp [2];
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    logic                    r_coeff_ready;

    logic [5:0]              w_pos;
    logic                    w_accept_coeff;
    logic                    w_accept_done;
    logic                    w_release;
    logic [BLOCK_SIZE-1:0]   w_wmask_nxt [2];
    logic [1:0]              w_full_nxt;
    logic                    w_wr_ptr_nxt;
    logic                    w_rd_ptr_nxt;

    generate
        if (ZIGZAG_EN) begin : g_zigzag
            zigzag_rom u_zigzag_rom (
                .i_zz_idx     (coeff_index),
                .o_raster_idx (w_pos)
            );
        end else begin : g_raster
            assign w_pos = coeff_index;
        end
    endgenerate

    assign w_accept_coeff = r_coeff_ready & coeff_valid;
    assign w_accept_done  = r_coeff_ready & block_done;
    assign w_release      = block_valid & block_ready;

    // Release only touches a full bank and writes only touch a non-full bank,
    // so the two updates below never target the same bank.
    always_comb begin
        w_full_nxt     = r_full;
        w_wmask_nxt[0] = r_wmask[0];
        w_wmask_nxt[1] = r_wmask[1];
        if (w_release) begin
            w_full_nxt[r_rd_ptr]  = 1'b0;
            w_wmask_nxt[r_rd_ptr] = '0;
        end
        if (w_accept_coeff) begin
            w_wmask_nxt[r_wr_ptr][w_pos] = 1'b1;
        end
        if (w_accept_done) begin
            w_full_nxt[r_wr_ptr] = 1'b1;
        end
        w_wr_ptr_nxt = r_wr_ptr ^ w_accept_done;
        w_rd_ptr_nxt = r_rd_ptr ^ w_release;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full        <= '0;
            r_wmask[0]    <= '0;
            r_wmask[1]    <= '0;
            r_comp[0]     <= '0;
            r_comp[1]     <= '0;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_coeff_ready <= 1'b1;
        end else begin
            r_full        <= w_full_nxt;
            r_wmask[0]    <= w_wmask_nxt[0];
            r_wmask[1]    <= w_wmask_nxt[1];
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_rd_ptr      <= w_rd_ptr_nxt;
            r_coeff_ready <= ~w_full_nxt[w_wr_ptr_nxt];
            if (w_accept_done) begin
                r_comp[r_wr_ptr] <= comp_id;
            end
        end
    end

    // Payload needs no reset: the written-mask gates every read.
    always_ff @(posedge clk) begin
        if (w_accept_coeff) begin
            r_data[r_wr_ptr][w_pos] <= coeff_in;
        end
    end

    always_comb begin
        block_out_flat = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            if (r_wmask[r_rd_ptr][i]) begin
                block_out_flat[i*WIDTH +: WIDTH] = r_data[r_rd_ptr][i];
            end
        end
    end

    assign coeff_ready     = r_coeff_ready;
    assign block_valid     = r_full[r_rd_ptr];
    assign block_comp      = r_comp[r_rd_ptr];
    assign blocks_buffered = 2'(r_full[0]) + 2'(r_full[1]);

endmodule

// File: tb/tb_coeff_block_pingpong.sv
module tb_coeff_block_pingpong;

    localparam int W  = 12;
    localparam int CW = 2;
    localparam int FW = W * 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic signed [W-1:0] coeff_in = '0;
    logic [5:0]          coeff_index = '0;
    logic                coeff_valid = 1'b0;
    logic                block_done = 1'b0;
    logic [CW-1:0]       comp_id = '0;
    logic                block_ready = 1'b0;

    logic          zz_ready, rw_ready;
    logic [FW-1:0] zz_flat, rw_flat;
    logic [CW-1:0] zz_comp, rw_comp;
    logic          zz_valid, rw_valid;
    logic [1:0]    zz_bb, rw_bb;

    coeff_block_pingpong #(.WIDTH(W), .ZIGZAG_EN(1'b1), .COMP_W(CW)) dut_zz (
        .clk(clk), .rst_n(rst_n), .coeff_in(coeff_in), .coeff_index(coeff_index),
        .coeff_valid(coeff_valid), .block_done(block_done), .comp_id(comp_id),
        .coeff_ready(zz_ready), .block_out_flat(zz_flat), .block_comp(zz_comp),
        .block_valid(zz_valid), .block_ready(block_ready), .blocks_buffered(zz_bb)
    );

    coeff_block_pingpong #(.WIDTH(W), .ZIGZAG_EN(1'b0), .COMP_W(CW)) dut_rw (
        .clk(clk), .rst_n(rst_n), .coeff_in(coeff_in), .coeff_index(coeff_index),
        .coeff_valid(coeff_valid), .block_done(block_done), .comp_id(comp_id),
        .coeff_ready(rw_ready), .block_out_flat(rw_flat), .block_comp(rw_comp),
        .block_valid(rw_valid), .block_ready(block_ready), .blocks_buffered(rw_bb)
    );

    // Reference model: a FIFO of completed blocks (at most two) plus the
    // block currently being assembled, kept in both orderings.
    typedef struct packed {
        logic [FW-1:0] zz;
        logic [FW-1:0] rw;
        logic [CW-1:0] comp;
    } blk_t;

    blk_t          q[$];
    blk_t          m_new;
    logic [FW-1:0] cur_zz = '0;
    logic [FW-1:0] cur_rw = '0;
    logic          m_ready = 1'b1;
    logic          m_rel, m_acc_c, m_acc_d;
    int            zz_tab[64];
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            cur_zz  = '0;
            cur_rw  = '0;
            m_ready = 1'b1;
        end else begin
            m_rel   = (q.size() > 0) && block_ready;
            m_acc_c = m_ready && coeff_valid;
            m_acc_d = m_ready && block_done;
            if (m_acc_c) begin
                cur_zz[zz_tab[coeff_index]*W +: W] = coeff_in;
                cur_rw[int'(coeff_index)*W +: W]   = coeff_in;
            end
            if (m_rel) void'(q.pop_front());
            if (m_acc_d) begin
                m_new.zz   = cur_zz;
                m_new.rw   = cur_rw;
                m_new.comp = comp_id;
                q.push_back(m_new);
                cur_zz = '0;
                cur_rw = '0;
            end
            m_ready = (q.size() < 2);
        end
    end

    always @(negedge clk) begin
        chk("zz_coeff_ready", FW'(zz_ready), FW'(m_ready));
        chk("rw_coeff_ready", FW'(rw_ready), FW'(m_ready));
        chk("zz_block_valid", FW'(zz_valid), FW'(q.size() > 0));
        chk("rw_block_valid", FW'(rw_valid), FW'(q.size() > 0));
        chk("zz_blocks_buffered", FW'(zz_bb), FW'(q.size()));
        chk("rw_blocks_buffered", FW'(rw_bb), FW'(q.size()));
        if (q.size() > 0) begin
            chk("zz_block_data", zz_flat, q[0].zz);
            chk("rw_block_data", rw_flat, q[0].rw);
            chk("zz_block_comp", FW'(zz_comp), FW'(q[0].comp));
            chk("rw_block_comp", FW'(rw_comp), FW'(q[0].comp));
        end
    end

    task automatic step(input logic v, input int idx, input int val,
                        input logic d, input int c, input logic r);
        coeff_valid = v;
        coeff_index = idx[5:0];
        coeff_in    = val[W-1:0];
        block_done  = d;
        comp_id     = c[CW-1:0];
        block_ready = r;
        @(posedge clk);
        #1;
        coeff_valid = 1'b0;
        block_done  = 1'b0;
    endtask

    task automatic drain();
        step(1'b0, 0, 0, 1'b0, 0, 1'b1);
        step(1'b0, 0, 0, 1'b0, 0, 1'b1);
        step(1'b0, 0, 0, 1'b0, 0, 1'b1);
    endtask

    logic [FW-1:0] exp_flat;

    initial begin
        int n;
        n = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 8 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
                    zz_tab[n] = r * 8 + (s - r);
                    n++;
                end
            end else begin
                for (int r = (s > 7 ? s - 7 : 0); r <= (s < 8 ? s : 7); r++) begin
                    zz_tab[n] = r * 8 + (s - r);
                    n++;
                end
            end
        end
        chk("model_zz_tab3", FW'(zz_tab[3]), FW'(16));
        chk("model_zz_tab9", FW'(zz_tab[9]), FW'(24));
        chk("model_zz_tab42", FW'(zz_tab[42]), FW'(15));

        repeat (3) @(posedge clk);
        #2;
        chk("reset_valid", FW'(zz_valid), '0);
        chk("reset_bb", FW'(zz_bb), '0);
        chk("reset_ready", FW'(zz_ready), FW'(1));
        chk("reset_comp", FW'(zz_comp), '0);
        chk("reset_flat", zz_flat, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // zigzag remap with EOB-free close on a separate cycle
        step(1'b1, 0, 100, 1'b0, 0, 1'b1);
        step(1'b1, 1, -5, 1'b0, 0, 1'b1);
        step(1'b1, 2, 7, 1'b0, 0, 1'b1);
        step(1'b0, 0, 0, 1'b1, 1, 1'b1);
        @(negedge clk);
        exp_flat = '0;
        exp_flat[0 +: W]  = 12'd100;
        exp_flat[W +: W]  = 12'hFFB;
        exp_flat[8*W +: W] = 12'd7;
        chk("t1_valid", FW'(zz_valid), FW'(1));
        chk("t1_zz_flat", zz_flat, exp_flat);
        chk("t1_comp", FW'(zz_comp), FW'(1));
        chk("t1_rw_entry2", FW'(rw_flat[2*W +: W]), FW'(12'd7));
        drain();

        // coefficient at the last position together with block_done
        step(1'b1, 63, -2048, 1'b1, 2, 1'b1);
        @(negedge clk);
        chk("t2_rw_entry63", FW'(rw_flat[63*W +: W]), FW'(12'h800));
        chk("t2_zz_entry63", FW'(zz_flat[63*W +: W]), FW'(12'h800));
        chk("t2_comp", FW'(rw_comp), FW'(2));
        drain();

        // both banks full, stall, then drain in order
        step(1'b1, 0, 10, 1'b1, 0, 1'b0);
        step(1'b1, 0, 20, 1'b1, 1, 1'b0);
        @(negedge clk);
        chk("t3_bb_full", FW'(zz_bb), FW'(2));
        chk("t3_ready_low", FW'(zz_ready), '0);
        step(1'b1, 0, 99, 1'b0, 0, 1'b0);
        @(negedge clk);
        chk("t3_first_dc", FW'(zz_flat[0 +: W]), FW'(12'd10));
        step(1'b0, 0, 0, 1'b0, 0, 1'b1);
        @(negedge clk);
        chk("t3_second_dc", FW'(zz_flat[0 +: W]), FW'(12'd20));
        chk("t3_ready_back", FW'(zz_ready), FW'(1));
        step(1'b0, 0, 0, 1'b0, 0, 1'b1);
        step(1'b0, 0, 0, 1'b1, 3, 1'b1);
        @(negedge clk);
        chk("t3_ignored_coeff", zz_flat, '0);
        drain();

        // bank reuse: full block, empty block, then a single DC
        for (int i = 0; i < 64; i++) step(1'b1, i, 1, i == 63, 0, 1'b1);
        step(1'b0, 0, 0, 1'b1, 1, 1'b1);
        step(1'b1, 0, 3, 1'b0, 0, 1'b1);
        step(1'b0, 0, 0, 1'b1, 2, 1'b1);
        @(negedge clk);
        exp_flat = '0;
        exp_flat[0 +: W] = 12'd3;
        chk("t4_zz_reuse", zz_flat, exp_flat);
        chk("t4_rw_reuse", rw_flat, exp_flat);
        drain();

        // release of one bank coinciding with close of the other
        step(1'b1, 0, 5, 1'b1, 0, 1'b0);
        step(1'b1, 0, 6, 1'b1, 1, 1'b1);
        @(negedge clk);
        chk("t5_bb", FW'(zz_bb), FW'(1));
        chk("t5_valid", FW'(zz_valid), FW'(1));
        chk("t5_dc", FW'(zz_flat[0 +: W]), FW'(12'd6));
        chk("t5_comp", FW'(zz_comp), FW'(1));
        drain();

        // reset in the middle of a block
        for (int i = 0; i < 10; i++) step(1'b1, i, i + 1, 1'b0, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", FW'(zz_valid), '0);
        chk("t6_rst_ready", FW'(zz_ready), FW'(1));
        chk("t6_rst_bb", FW'(rw_bb), '0);
        chk("t6_rst_flat", rw_flat, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        step(1'b0, 0, 0, 1'b1, 3, 1'b1);
        @(negedge clk);
        chk("t6_eob_valid", FW'(zz_valid), FW'(1));
        chk("t6_eob_zz_flat", zz_flat, '0);
        chk("t6_eob_rw_flat", rw_flat, '0);
        chk("t6_eob_comp", FW'(zz_comp), FW'(3));
        drain();

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 599) == 0) begin
                #2;
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                #1;
            end
            step($urandom_range(0, 9) < 7, int'($urandom_range(0, 63)), int'($urandom),
                 $urandom_range(0, 99) < 15, int'($urandom_range(0, 3)),
                 $urandom_range(0, 9) < 6);
        end
        drain();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
